sub_rr_arbiter: RTL and testbench
=================================

Name: sub_rr_arbiter

Overview:
- Shares one sub_32bit_unsigned instance (A - B, result + borrow) among NUM_REQ requesters.
- Per-requester valid/ready request channels; single valid/ready response channel tagged with requester ID.
- Round-robin grant, one registered output stage, throughput of one subtraction per cycle.
- Sits between the requesting datapath clients and the shared subtractor.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the response ID (derived, not overridden).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, bit i = requester i.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_a  in  NUM_REQ*32  minuends; requester i at bits [32i+31:32i].
- req_b  in  NUM_REQ*32  subtrahends; same packing as req_a.
- rsp_valid  out  1  response register holds a valid result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_result  out  32  A - B mod 2^32.
- rsp_borrow  out  1  1 iff A < B (unsigned).
- busy  out  1  rsp_valid OR any req_valid.
- op_count  out  CNTW  number of responses accepted (rsp_valid & rsp_ready), wraps modulo 2^CNTW.

Behaviour:
- Reset (rst_n=0, asynchronous): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_borrow=0, op_count=0, last_grant=NUM_REQ-1 (requester 0 has top priority first). req_ready=0 while in reset.
- State machine (output register), two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY when rsp_ready and there is no grant.
  - FULL -> FULL when rsp_ready with a grant; back-to-back, new data loaded.
  - FULL holds when rsp_ready=0.
- can_accept = !rsp_valid | rsp_ready (combinational).
- Grant: when can_accept, req_ready gets a single bit set for the first i with req_valid[i]=1, searching from last_grant+1 upward with wrap at NUM_REQ-1 -> 0. req_ready is all zero when !can_accept or no req_valid.
- req_ready may depend combinationally on req_valid and rsp_ready. Requesters must not gate req_valid on req_ready.
- Requester rules: once req_valid[i] is asserted, it holds req_valid, req_a and req_b stable until accepted.
- On grant of i at edge k:
  - rsp_result/rsp_borrow get the subtractor output for (req_a[i], req_b[i]).
  - rsp_id <= i, last_grant <= i.
  - Response is visible after edge k; latency 1 cycle.
- Ungranted cycles leave last_grant unchanged.
- While FULL and rsp_ready=0: rsp_id, rsp_result and rsp_borrow stay frozen; no grant.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Arithmetic: result wraps modulo 2^32. Borrow is the subtractor's borrow-out; no signed interpretation.
- op_count increments on each rsp_valid & rsp_ready edge; wraps 0xFFFF -> 0x0000 at the default width.
- Reset mid-operation: a pending response is discarded, the pointer returns to the reset value, and nothing is replayed.
- Boundary cases match the subtractor: 0-1 gives 0xFFFFFFFF with borrow 1; 0-0xFFFFFFFF gives 1 with borrow 1; equal operands give 0 with borrow 0.

Test Plan:
- Single request, rsp_ready=1: req_valid=0001, A=3000000000, B=1000000000 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, id=0, result=2000000000, borrow=0; op_count=1.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1,...; one response per cycle; no gaps.
- Back-pressure: response pending with rsp_ready=0 for 5 cycles -> req_ready=0; rsp outputs stable; the first rsp_ready=1 cycle both drains and grants the next request.
- Borrow corners, one per request:
  - A=0, B=1 -> 0xFFFFFFFF, borrow 1.
  - A=0, B=0xFFFFFFFF -> 1, borrow 1.
  - A=B=0xFFFFFFFF -> 0, borrow 0.
- Fairness: requester 0 always valid, requester 2 raises valid -> requester 2 is granted within 2 grants.
- Reset mid-operation: rst_n pulled low while FULL and rsp_ready=0 -> rsp_valid=0 immediately, without waiting for a clock edge; op_count=0; after release, the first grant goes to the lowest valid index. Random regression of 20000 requests is scoreboarded by id.

Source files
------------

// File: rtl/sub_rr_arbiter.sv
// rtl/sub_rr_arbiter.sv - round-robin arbiter sharing one 32-bit unsigned subtractor
//
// sub_32bit_unsigned: combinational A - B with borrow-out.
//   a, b        32-bit unsigned operands
//   result      a - b mod 2^32
//   borrow      1 iff a < b
//
// sub_rr_arbiter: NUM_REQ valid/ready request channels feed one shared
// subtractor; results leave through a single registered valid/ready
// response channel tagged with the owning requester index.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b            packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester index owning the response
//   rsp_result, rsp_borrow  subtraction result and borrow
//   busy                    response pending or any request valid
//   op_count                accepted responses, wraps modulo 2^CNTW

module sub_32bit_unsigned (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        borrow
);

    // A zero-extended 33-bit difference leaves the borrow in the top bit.
    logic [32:0] diff;

    assign diff   = {1'b0, a} - {1'b0, b};
    assign result = diff[31:0];
    assign borrow = diff[32];

endmodule

module sub_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ),
    parameter  int CNTW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_borrow,
    output logic                  busy,
    output logic [CNTW-1:0]       op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;

    logic           can_accept;
    logic           found;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [31:0]    sub_result;
    logic           sub_borrow;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    assign busy       = rsp_valid || (|req_valid);

    // Round-robin search: first look strictly above last_grant, then wrap
    // and take the lowest valid index. The second pass also catches
    // last_grant itself when it is the only valid requester.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i > int'(last_grant))) begin
                found     = 1'b1;
                grant_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

    // rst_n gates the grant so req_ready stays low for the whole reset,
    // not only after the first edge.
    assign grant_any = found && can_accept && rst_n;

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = grant_any;
                sel_a        = req_a[i*32 +: 32];
                sel_b        = req_b[i*32 +: 32];
            end
        end
    end

    sub_32bit_unsigned u_sub (
        .a      (sel_a),
        .b      (sel_b),
        .result (sub_result),
        .borrow (sub_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_borrow <= 1'b0;
            op_count   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else begin
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + 1'b1;
            end

            // grant_any already implies can_accept, so loading here never
            // overwrites a response the consumer has not taken.
            if (grant_any) begin
                rsp_id     <= grant_idx;
                rsp_result <= sub_result;
                rsp_borrow <= sub_borrow;
                last_grant <= grant_idx;
            end

            case (state)
                EMPTY: begin
                    if (grant_any) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (rsp_ready && !grant_any) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// tb/tb_sub_rr_arbiter.sv - scoreboard bench for sub_rr_arbiter

module tb_sub_rr_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;
    localparam int NUM_RANDOM = 20000;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_borrow;
    logic              busy;
    logic [CNTW-1:0]   op_count;

    sub_rr_arbiter #(.NUM_REQ(N), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_borrow (rsp_borrow),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    r;
        logic           b;
    } rsp_t;

    rsp_t            expq [$];
    logic [63:0]     reqq [N][$];
    int              vectors = 0;
    int              miscompares = 0;
    logic            m_full = 1'b0;
    int              m_ptr = N - 1;
    logic [CNTW-1:0] m_cnt = '0;
    logic [N-1:0]    acc = '0;
    int              rdy_mode = 0;
    int              waitc [N];
    int              g;
    logic [N-1:0]    er;
    rsp_t            e;
    logic [63:0]     h;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: first valid index after pointer p, modulo N.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand32();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic any_pending();
        for (int i = 0; i < N; i++) begin
            if (reqq[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model and per-cycle control checks; also issues the
    // expected responses into the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_full = 1'b0;
            m_ptr  = N - 1;
            m_cnt  = '0;
            acc    = '0;
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else begin
            g  = -1;
            er = '0;
            if (!m_full || rsp_ready) g = model_pick(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, m_full);
            chk("op_count", op_count, m_cnt);
            chk("busy", busy, m_full | (|req_valid));
            acc = req_ready;

            if (|req_ready) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) waitc[i] = 0;
                    else if (req_valid[i]) begin
                        waitc[i]++;
                        chk("fair_wait", waitc[i] <= N - 1, 1);
                    end else waitc[i] = 0;
                end
            end

            if (m_full && rsp_ready) m_cnt = m_cnt + 1'b1;
            if (g >= 0) begin
                h    = {req_a[g*32 +: 32], req_b[g*32 +: 32]};
                e.id = IDW'(g);
                e.r  = h[63:32] - h[31:0];
                e.b  = (h[63:32] < h[31:0]);
                expq.push_back(e);
                m_ptr  = g;
                m_full = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
            end else begin
                chk("rsp_id", rsp_id, expq[0].id);
                chk("rsp_result", rsp_result, expq[0].r);
                chk("rsp_borrow", rsp_borrow, expq[0].b);
                if (rsp_ready) void'(expq.pop_front());
            end
        end
    end

    // Requester/consumer driver: hold each head until accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && reqq[i].size() > 0) void'(reqq[i].pop_front());
            if (reqq[i].size() > 0) begin
                logic [63:0] hd;
                hd = reqq[i][0];
                req_valid[i]       = 1'b1;
                req_a[i*32 +: 32]  = hd[63:32];
                req_b[i*32 +: 32]  = hd[31:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        if (rdy_mode == 2) rsp_ready = ($urandom % 4) != 0;
        else rsp_ready = (rdy_mode == 0);
    end

    task automatic drain();
        int t = 0;
        while ((any_pending() || expq.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", expq.size());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int issued;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        rdy_mode = 0;

        // Reset state, with a request already waiting.
        reqq[0].push_back({32'd3000000000, 32'd1000000000});
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_borrow", rsp_borrow, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // All requesters continuously valid.
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < N; i++) reqq[i].push_back({rand32(), rand32()});
        drain();

        // Back-pressure with a second request waiting.
        rdy_mode = 1;
        reqq[1].push_back({rand32(), rand32()});
        reqq[3].push_back({rand32(), rand32()});
        repeat (8) @(posedge clk);
        rdy_mode = 0;
        drain();

        // Borrow corners.
        reqq[0].push_back({32'h0, 32'h1});
        reqq[0].push_back({32'h0, 32'hFFFF_FFFF});
        reqq[0].push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
        drain();

        // Fairness: requester 2 joins a continuously busy requester 0.
        for (int k = 0; k < 10; k++) reqq[0].push_back({rand32(), rand32()});
        repeat (2) @(posedge clk);
        reqq[2].push_back({rand32(), rand32()});
        drain();

        // Reset while a response is held.
        rdy_mode = 1;
        reqq[1].push_back({rand32(), rand32()});
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_req_ready", req_ready, 0);
        reqq[3].push_back({rand32(), rand32()});
        reqq[2].push_back({rand32(), rand32()});
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 0;
        drain();

        // Random regression.
        rdy_mode = 2;
        issued = 0;
        while (issued < NUM_RANDOM) begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (issued < NUM_RANDOM && reqq[i].size() < 2 && ($urandom % 3) == 0) begin
                    reqq[i].push_back({rand32(), rand32()});
                    issued++;
                end
            end
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
